// File: rtl/lab3_cache_assoc_pkg.sv
// Shared types for the set-associative cache controller: FSM state encoding,
// request type constants and a lowest-set one-hot to binary encoder.
package lab3_cache_assoc_pkg;

  typedef enum logic [2:0] {
    IDLE, TAG, EVICT, REFILL, WAIT, RESP, FLUSH, FDONE
  } state_t;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Lowest set bit wins, so a (malformed) multi-hit still picks one way.
  function automatic logic [2:0] oh2bin(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/lab3_cache_victim_sel.sv
// Victim selection: lowest-numbered invalid way of the set, otherwise the
// set's round-robin pointer. Pointers advance once per completed refill.
module lab3_cache_victim_sel
  import lab3_cache_assoc_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_W-1:0]    idx,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic                adv,
  output logic [WAY_W-1:0]    victim
);

  logic [NUM_SETS-1:0][WAY_W-1:0] ptr;

  // Invalid ways take precedence over the round-robin choice.
  always_comb begin
    victim = ptr[idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) victim = WAY_W'(w);
  end

  // Per-set pointer; power-of-two way count makes the add wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else if (adv && (NUM_WAYS > 1))
      ptr[idx] <= ptr[idx] + WAY_W'(1);
  end

endmodule

// File: rtl/lab3_cache_assoc_ctrl.sv
// Control FSM for a write-back, write-allocate N-way set-associative cache:
// hit, evict, refill and whole-cache flush sequencing toward an external
// datapath. Optional statistics counters under LAB3_CACHE_ASSOC_STATS_EN.
module lab3_cache_assoc_ctrl
  import lab3_cache_assoc_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                memreq_val,
  output logic                memreq_rdy,
  input  logic                memreq_type,
  input  logic [IDX_W-1:0]    memreq_idx,
  output logic                memresp_val,
  input  logic                memresp_rdy,
  input  logic [NUM_WAYS-1:0] tag_match,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  output logic [IDX_W-1:0]    arr_idx,
  output logic [WAY_W-1:0]    arr_way,
  output logic                tarray_wen,
  output logic                darray_wen,
  output logic                refill_sel,
  output logic                dirty_wen,
  output logic                dirty_wdata,
  output logic                evict_val,
  input  logic                evict_rdy,
  output logic                refill_val,
  input  logic                refill_rdy,
  input  logic                refill_done,
  input  logic                flush,
  output logic                flush_done
`ifdef LAB3_CACHE_ASSOC_STATS_EN
  ,
  output logic [31:0]         stat_hits,
  output logic [31:0]         stat_misses,
  output logic [31:0]         stat_evicts
`endif
);

  state_t            state, nxt;
  logic              req_type;
  logic [IDX_W-1:0]  req_idx;
  logic [WAY_W-1:0]  vic, vic_q, hit_way;
  logic [IDX_W-1:0]  fset;
  logic [WAY_W-1:0]  fway;
  logic              live, adv, f_step, f_last, hit;

  assign hit     = |tag_match;
  assign hit_way = WAY_W'(oh2bin(8'(tag_match)));
  assign f_last  = (fset == IDX_W'(NUM_SETS - 1)) && (fway == WAY_W'(NUM_WAYS - 1));

  lab3_cache_victim_sel #(
    .NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .WAY_W(WAY_W)
  ) u_vsel (
    .clk(clk), .reset_n(reset_n), .idx(req_idx), .way_valid(way_valid),
    .adv(adv), .victim(vic)
  );

  // Next-state and all array/handshake controls.
  always_comb begin
    nxt         = state;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    arr_idx     = req_idx;
    arr_way     = '0;
    tarray_wen  = 1'b0;
    darray_wen  = 1'b0;
    refill_sel  = 1'b0;
    dirty_wen   = 1'b0;
    dirty_wdata = 1'b0;
    evict_val   = 1'b0;
    refill_val  = 1'b0;
    flush_done  = 1'b0;
    adv         = 1'b0;
    f_step      = 1'b0;
    case (state)
      IDLE: begin
        // live keeps rdy low until the first clock after reset release
        memreq_rdy = live && !flush;
        if (live && flush)                   nxt = FLUSH;
        else if (memreq_val && memreq_rdy)   nxt = TAG;
      end
      TAG: begin
        if (hit) begin
          arr_way = hit_way;
          if (req_type == REQ_WRITE) begin
            darray_wen  = 1'b1;
            dirty_wen   = 1'b1;
            dirty_wdata = 1'b1;
          end
          nxt = RESP;
        end else begin
          arr_way = vic;
          nxt = (way_valid[vic] && way_dirty[vic]) ? EVICT : REFILL;
        end
      end
      EVICT: begin
        arr_way   = vic_q;
        evict_val = 1'b1;
        if (evict_rdy) begin
          dirty_wen = 1'b1;
          nxt       = REFILL;
        end
      end
      REFILL: begin
        arr_way    = vic_q;
        refill_val = 1'b1;
        if (refill_rdy) nxt = WAIT;
      end
      WAIT: begin
        arr_way = vic_q;
        if (refill_done) begin
          tarray_wen  = 1'b1;
          darray_wen  = 1'b1;
          refill_sel  = 1'b1;
          dirty_wen   = 1'b1;
          dirty_wdata = (req_type != REQ_READ);
          adv         = 1'b1;
          nxt         = TAG;
        end
      end
      RESP: begin
        memresp_val = 1'b1;
        if (memresp_rdy) nxt = IDLE;
      end
      FLUSH: begin
        arr_idx = fset;
        arr_way = fway;
        if (way_valid[fway] && way_dirty[fway]) begin
          evict_val = 1'b1;
          if (evict_rdy) begin
            dirty_wen = 1'b1;
            f_step    = 1'b1;
          end
        end else begin
          f_step = 1'b1;
        end
        if (f_step && f_last) nxt = FDONE;
      end
      FDONE: begin
        flush_done = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, request latch, victim latch and flush walk counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      live     <= 1'b0;
      req_type <= REQ_READ;
      req_idx  <= '0;
      vic_q    <= '0;
      fset     <= '0;
      fway     <= '0;
    end else begin
      state <= nxt;
      live  <= 1'b1;
      if (state == IDLE && memreq_val && memreq_rdy) begin
        req_type <= memreq_type;
        req_idx  <= memreq_idx;
      end
      if (state == TAG && !hit) vic_q <= vic;
      if (f_step) begin
        if (fway == WAY_W'(NUM_WAYS - 1)) begin
          fway <= '0;
          fset <= fset + IDX_W'(1);
        end else begin
          fway <= fway + WAY_W'(1);
        end
      end
    end
  end

  a_onehot_hit: assert property (@(posedge clk) disable iff (!reset_n)
    (state == TAG) |-> $onehot0(tag_match));

`ifdef LAB3_CACHE_ASSOC_STATS_EN
  logic replay;

  // Saturating event counters; the post-refill replay hit is not a new hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      replay      <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else begin
      if (state == IDLE && memreq_val && memreq_rdy) replay <= 1'b0;
      if (state == WAIT && refill_done)              replay <= 1'b1;
      if (state == TAG && hit && !replay && stat_hits != '1)
        stat_hits <= stat_hits + 32'd1;
      if (state == TAG && !hit && stat_misses != '1)
        stat_misses <= stat_misses + 32'd1;
      if (state == EVICT && evict_rdy && stat_evicts != '1)
        stat_evicts <= stat_evicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/lab3_cache_assoc_ctrl.md
Name: lab3_cache_assoc_ctrl

Overview:
Control unit for a parametrised, write-back, write-allocate, N-way set-associative cache. It pairs with a separate datapath that holds the tag, data, valid and dirty arrays. The block sequences hit, evict, refill and whole-cache flush. It drives per-way array enables and a per-set round-robin victim pointer, and sits between the processor memreq/memresp interface and the batch line-transfer units.

Parameters:
NUM_WAYS, 2, ways per set; power of two, 1..8
NUM_SETS, 16, sets; power of two, 2..256
IDX_W, $clog2(NUM_SETS), set index width (derived)
WAY_W, max(1,$clog2(NUM_WAYS)), way id width (derived)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
memreq_val  in  1  processor request valid
memreq_rdy  out  1  request accepted
memreq_type  in  1  0 = read, 1 = write
memreq_idx  in  IDX_W  set index of the request
memresp_val  out  1  response valid
memresp_rdy  in  1  response accepted
tag_match  in  NUM_WAYS  per-way hit for the latched request
way_valid  in  NUM_WAYS  per-way valid bits of the latched set
way_dirty  in  NUM_WAYS  per-way dirty bits of the latched set
arr_idx  out  IDX_W  set index driven to the arrays
arr_way  out  WAY_W  way selected for read/write
tarray_wen  out  1  tag+valid write
darray_wen  out  1  data write (full line on refill, word on write hit)
refill_sel  out  1  data-write source is the refill line
dirty_wen  out  1  dirty-bit write
dirty_wdata  out  1  dirty-bit value
evict_val  out  1  start line write-back of arr_idx/arr_way
evict_rdy  in  1  write-back unit accepted
refill_val  out  1  start line fetch
refill_rdy  in  1  fetch unit accepted
refill_done  in  1  one-cycle pulse: line data available
flush  in  1  flush request (level)
flush_done  out  1  one-cycle pulse: flush complete

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; victim pointers 0; flush counter 0.
- FSM states: IDLE, TAG, EVICT, REFILL, WAIT, RESP, FLUSH, FDONE.
- IDLE: memreq_rdy = !flush. Accept on val&&rdy, latch type and idx, go to TAG. If flush is high and no request is in progress, go to FLUSH. Flush has priority over a same-cycle memreq_val.
- TAG (1 cycle; arrays read combinationally):
  - Hit (|tag_match): arr_way = encoded hit way. On write, darray_wen=1, dirty_wen=1, dirty_wdata=1. Go to RESP. Hit latency: 2 cycles from accept to memresp_val.
  - Miss: victim = lowest-numbered invalid way, else victim_ptr[idx]. Latch the victim. If victim is valid and dirty, go to EVICT; else go to REFILL.
  - Multiple tag_match bits set: assertion error; the lowest way is used.
- EVICT: evict_val=1 until evict_rdy. On the handshake, dirty_wen=1 with dirty_wdata=0. Go to REFILL.
- REFILL: refill_val=1 until refill_rdy, then go to WAIT.
- WAIT: on refill_done, assert tarray_wen, darray_wen and refill_sel. Set dirty_wen=1 with dirty_wdata=type. If not NUM_WAYS==1, victim_ptr[idx] increments modulo NUM_WAYS. Go to TAG; the replay hits.
- RESP: memresp_val=1; hold until memresp_rdy, then go to IDLE. Back-to-back requests: one per 3 cycles minimum.
- FLUSH: counter walks sets 0..NUM_SETS-1 and, within each set, ways 0..NUM_WAYS-1, one slot per step. If the slot is valid and dirty, evict_val=1; the counter advances on evict_rdy, with dirty_wen=1 and dirty_wdata=0. Otherwise it advances with no evict. After the last slot (wrap to 0), go to FDONE.
- FDONE: flush_done=1 for one cycle, then go to IDLE. Flush deasserted mid-walk is ignored; the walk completes.
- The datapath must present tag_match/way_valid/way_dirty for arr_idx in the same cycle.

Optional Feature:
- Macro LAB3_CACHE_ASSOC_STATS_EN.
- When defined: adds outputs stat_hits[31:0], stat_misses[31:0] and stat_evicts[31:0]. Each counts once per event: TAG hit on first pass only, TAG miss, EVICT handshake. Flush evicts are excluded. Counters saturate at 2^32-1 and reset to 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package lab3_cache_assoc_pkg holds the state enum, the READ/WRITE type constants, and a one-hot-to-binary function (lowest-set priority).
- One sub-module, lab3_cache_victim_sel: per-set round-robin pointers plus the invalid-way priority pick.

Test Plan:
- Read miss, clean: NUM_WAYS=2, cold cache, read idx 3 → refill_val, no evict_val; on refill_done, tarray_wen on way 0, then memresp_val.
- Write hit: after the above, write idx 3 → memresp_val 2 cycles after accept; dirty_wen=1, dirty_wdata=1, arr_way=0.
- Dirty eviction: fill both ways of idx 3 with writes, then a third tag → evict of way 0 (pointer 0); a fourth tag evicts way 1.
- Backpressure: hold evict_rdy=0 for 5 cycles, then memresp_rdy=0 for 3 cycles → valids held stable, exactly one response.
- Flush: NUM_SETS=4, 3 dirty lines → exactly 3 evict handshakes, flush_done pulses once, all dirty bits cleared; memreq_rdy=0 throughout.
- Reset mid-refill: drop reset_n while in WAIT → all outputs 0 immediately; after release, first request is accepted normally.
